// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, constants and payload types for the instruction fetch stage.
// IF_MISALIGN_CHECK_EN adds the redirect alignment helper.
package if_fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 8;

    localparam logic [ADDR_W-1:0]  RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;
    localparam logic [ADDR_W-1:0]  PC_INC               = 32'h0000_0004;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

`ifdef IF_MISALIGN_CHECK_EN
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction
`endif

endpackage

// File: rtl/if_fetch_fifo.sv
// Show-ahead FIFO with flush; head word is visible on data_o whenever not empty.
module if_fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i & (count_q != '0);
        do_push  = push_i & (count_q != CNT_W'(DEPTH));
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues imem requests, buffers words.
// IF_MISALIGN_CHECK_EN adds a sticky misalign_o flag and aligns redirect targets.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned        DEPTH        = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic               misalign_o
`endif
);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  live;
    logic [CNT_W-1:0]  fifo_count, pcq_count;
    logic              accept, rsp_keep;
    logic              fifo_push, fifo_pop;
    logic              fifo_empty, fifo_full;
    logic              pcq_empty, pcq_full;
    logic [ADDR_W-1:0] pcq_head;
    fetch_entry_t      fifo_in, fifo_head;

    always_comb begin
        live           = inflight_q - discard_q;
        imem_req_valid = rst & ~redirect & ((fifo_count + live) < CNT_W'(DEPTH));
        imem_req_addr  = fpc_q;
        accept         = imem_req_valid & imem_req_ready;
        rsp_keep       = imem_rsp_valid & ~redirect & (discard_q == '0) & ~pcq_empty;

        fifo_push      = rsp_keep;
        fifo_in        = '{pc: pcq_head, instr: imem_rsp_data};

        valid_o        = rst & ~fifo_empty;
        instruction_o  = valid_o ? fifo_head.instr : NOP_INSTR;
        pc_o           = valid_o ? fifo_head.pc : (rst ? last_pc_q : RESET_VECTOR);
        fifo_pop       = valid_o & ~stall & ~redirect;

`ifdef IF_MISALIGN_CHECK_EN
        target         = align_word(redirect_pc);
`else
        target         = redirect_pc;
`endif

        last_pc_d  = valid_o ? fifo_head.pc : last_pc_q;
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
        fpc_d      = fpc_q;
        discard_d  = discard_q;
        if (redirect) begin
            fpc_d     = target;
            // Every request still outstanding after this cycle belongs to the old path.
            discard_d = inflight_d;
        end else begin
            if (accept) fpc_d = fpc_q + PC_INC;
            if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc_q      <= RESET_VECTOR;
            last_pc_q  <= RESET_VECTOR;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fpc_q      <= fpc_d;
            last_pc_q  <= last_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q | (redirect & (redirect_pc[1:0] != 2'b00));
        misalign_o = misalign_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end
`endif

    if_fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fifo_in),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Addresses of live (non-discarded) requests, oldest first.
    if_fetch_fifo #(
        .W     (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (accept),
        .pop_i   (rsp_keep),
        .data_i  (fpc_q),
        .data_o  (pcq_head),
        .count_o (pcq_count),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    push_while_full_a: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && fifo_full));
    pcq_overflow_a: assert property (@(posedge clk) disable iff (!rst)
        !(accept && pcq_full));
    live_count_a: assert property (@(posedge clk) disable iff (!rst)
        (pcq_count == live));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit with a queue-based fetch model and an in-order memory.
module tb_if_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, valid_o;
    logic [31:0] imem_req_addr, imem_rsp_data, instruction_o, pc_o;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction_o  (instruction_o),
        .pc_o           (pc_o),
        .valid_o        (valid_o)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Memory: accepted addresses awaiting their response, in order.
    logic [31:0] mem_q[$];
    // Model: fetch pc, buffered word addresses, outstanding requests tagged live/stale.
    logic [31:0] m_fpc, m_last_pc;
    logic [31:0] m_fifo[$];
    logic [31:0] m_out_addr[$];
    bit          m_out_live[$];
    bit          m_misalign;

    bit          obs_valid, obs_req;
    logic [31:0] obs_pc;
    logic [31:0] col_pc [4];
    int          col_first;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance model at posedge.
    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit rdy, input bit rsp_en);
        bit          e_req, e_valid, e_mis, acc_m, acc_dut, live_tag;
        logic [31:0] e_instr, e_pc, tgt, req_addr, a;
        int          live;
        @(negedge clk);
        rst            = r;
        stall          = st;
        redirect       = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        imem_rsp_valid = r && rsp_en && (mem_q.size() > 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(mem_q[0]) : 32'hDEAD_BEEF;
        #1;
        live = 0;
        foreach (m_out_live[i]) if (m_out_live[i]) live++;
        e_req   = r && !rd && (m_fifo.size() + live < DEPTH);
        e_valid = r && (m_fifo.size() > 0);
        e_instr = e_valid ? mem_word(m_fifo[0]) : NOP;
        e_pc    = e_valid ? m_fifo[0] : (r ? m_last_pc : RV);
        e_mis   = m_misalign;
        check1("imem_req_valid", imem_req_valid, e_req);
        if (e_req) check32("imem_req_addr", imem_req_addr, m_fpc);
        check1("valid_o", valid_o, e_valid);
        check32("instruction_o", instruction_o, e_instr);
        check32("pc_o", pc_o, e_pc);
`ifdef IF_MISALIGN_CHECK_EN
        check1("misalign_o", misalign_o, e_mis);
`endif
        obs_valid = valid_o;
        obs_pc    = pc_o;
        obs_req   = imem_req_valid;
        req_addr  = imem_req_addr;
        acc_dut   = imem_req_valid && rdy;
        acc_m     = e_req && rdy;
        @(posedge clk);
        if (!r) begin
            mem_q.delete();
            m_fpc = RV;
            m_last_pc = RV;
            m_fifo.delete();
            m_out_addr.delete();
            m_out_live.delete();
            m_misalign = 1'b0;
        end else begin
            if (imem_rsp_valid) void'(mem_q.pop_front());
            if (acc_dut) mem_q.push_back(req_addr);
            if (e_valid) m_last_pc = m_fifo[0];
            if (e_valid && !st && !rd) void'(m_fifo.pop_front());
            if (imem_rsp_valid && m_out_addr.size() > 0) begin
                a        = m_out_addr.pop_front();
                live_tag = m_out_live.pop_front();
                if (live_tag && !rd) m_fifo.push_back(a);
            end
            if (rd) begin
`ifdef IF_MISALIGN_CHECK_EN
                tgt = {rpc[31:2], 2'b00};
                if (rpc[1:0] != 2'b00) m_misalign = 1'b1;
`else
                tgt = rpc;
`endif
                m_fifo.delete();
                foreach (m_out_live[i]) m_out_live[i] = 1'b0;
                m_fpc = tgt;
            end else if (acc_m) begin
                m_out_addr.push_back(m_fpc);
                m_out_live.push_back(1'b1);
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    // Free-run with an ideal memory and record the first n delivered pcs.
    task automatic collect(input int n);
        int got = 0;
        col_first = -1;
        for (int i = 0; i < 4; i++) col_pc[i] = 32'hBAD0_BAD0;
        for (int k = 0; k < 40 && got < n; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_valid) begin
                if (col_first < 0) col_first = k;
                col_pc[got] = obs_pc;
                got++;
            end
        end
        check_int("collect_count", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        m_fpc = RV; m_last_pc = RV; m_misalign = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check1("reset_valid", obs_valid, 1'b0);
        check32("reset_pc", obs_pc, RV);
        check1("reset_req", obs_req, 1'b0);

        collect(4);
        check_int("first_fetch_latency", col_first, 2);
        check32("seq_pc0", col_pc[0], 32'h0);
        check32("seq_pc1", col_pc[1], 32'h4);
        check32("seq_pc2", col_pc[2], 32'h8);
        check32("seq_pc3", col_pc[3], 32'hC);

        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check1("stall_full_req", obs_req, 1'b0);
        check1("stall_full_valid", obs_valid, 1'b1);
        collect(3);

        step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        collect(2);
        check32("redir_pc0", col_pc[0], 32'h100);
        check32("redir_pc1", col_pc[1], 32'h104);

        guard = 0;
        while ((mem_q.size() == 0 || m_fifo.size() == 0) && guard < 20) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, m_fifo.size() == 0);
            guard++;
        end
        check1("setup_rsp_and_head", guard < 20, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check1("valid_after_stalled_redirect", obs_valid, 1'b0);
        collect(2);
        check32("stall_redir_pc0", col_pc[0], 32'h100);
        check32("stall_redir_pc1", col_pc[1], 32'h104);

        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        collect(2);
        check32("wrap_pc0", col_pc[0], 32'hFFFF_FFFC);
        check32("wrap_pc1", col_pc[1], 32'h0000_0000);

        guard = 0;
        while (m_fifo.size() < 2 && guard < 20) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            guard++;
        end
        check1("setup_two_buffered", guard < 20, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check1("midreset_valid", obs_valid, 1'b0);
        check32("midreset_pc", obs_pc, RV);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check1("post_reset_valid", obs_valid, 1'b0);
        check32("post_reset_pc", obs_pc, RV);
        collect(1);
        check32("refetch_pc", col_pc[0], RV);

`ifdef IF_MISALIGN_CHECK_EN
        step(1'b1, 1'b0, 1'b1, 32'h102, 1'b1, 1'b0);
        collect(1);
        check32("misalign_fetch_pc", col_pc[0], 32'h100);
        check1("misalign_flag", misalign_o, 1'b1);
`endif

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1);
        collect(1);
        check32("back_to_back_redirect_pc", col_pc[0], 32'h400);

        for (int i = 0; i < 1500; i++) begin
            step(1'b1,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 5,
                 $urandom,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage; the producer that drives instruction_i/pc_i of the IF/ID pipeline register and honours the same stall signal.
- Owns the fetch PC, issues requests to instruction memory over a valid/ready request channel plus an in-order response channel, and buffers returned words in a small prefetch FIFO.
- Handles branch/jump redirect by flushing buffered words and discarding in-flight responses.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, prefetch FIFO entries and maximum outstanding requests; power of two, at least 2.
- NOP_INSTR, 32'h0000_0013, instruction_o value when valid_o=0 (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- stall  in  1  downstream hold; head entry is not consumed while 1.
- redirect  in  1  taken branch/jump from EX.
- redirect_pc  in  32  new fetch address, valid with redirect.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response word valid; responses arrive in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- instruction_o  out  32  to IF/ID instruction_i.
- pc_o  out  32  to IF/ID pc_i; address of instruction_o.
- valid_o  out  1  instruction_o/pc_o are real.

Behaviour:
- Reset (rst=0 at posedge):
  - fpc=RESET_VECTOR; FIFO empty; inflight=0; discard=0.
  - Outputs: valid_o=0, instruction_o=NOP_INSTR, pc_o=RESET_VECTOR, imem_req_valid=0 during the reset cycle.
  - Reset asserted mid-transaction drops all state. Responses to pre-reset requests are not expected; the memory is reset together with this block.
- Request issue:
  - imem_req_valid = ~redirect & (fifo_count + inflight - discard < DEPTH).
  - imem_req_addr = fpc.
  - On accept (valid & ready): fpc += 4 with 32-bit wrap (32'hFFFF_FFFC -> 0), and inflight += 1.
  - A PC queue (depth DEPTH) records the address of each accepted, non-discarded request.
- Response handling:
  - Each imem_rsp_valid decrements inflight.
  - If discard>0: the word is dropped and discard decrements.
  - Otherwise {pc queue head, data} is pushed to the FIFO and the pc queue is popped.
  - Admission rule guarantees the FIFO never overflows. A push while full is an assertion failure.
- Output (show-ahead):
  - valid_o = FIFO non-empty.
  - instruction_o/pc_o = head entry; NOP_INSTR/last pc_o when empty.
  - Pop when valid_o & ~stall.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - An empty FIFO with a same-cycle push has zero bypass: the word appears the next cycle. Fetch latency is therefore accept -> rsp (1 cycle or more) -> valid_o one cycle after rsp.
- Redirect (highest priority):
  - fpc <= redirect_pc; FIFO and pc queue cleared; no request issued that cycle.
  - discard <= inflight after this cycle's response. A response arriving in the redirect cycle is dropped and counted.
  - valid_o=0 in the following cycle, regardless of stall.
- Redirect while stall=1: redirect still wins; the stalled head is discarded.
- Back-to-back redirects: the second overrides fpc; discard accumulates correctly.
- Redirect with inflight=0: discard=0; the new fetch issues the next cycle.

Optional Feature:
- IF_MISALIGN_CHECK_EN
  - Defined:
    - Adds output misalign_o (1 bit).
    - A redirect with redirect_pc[1:0]!=0 sets misalign_o sticky until reset, and the target is loaded with low bits forced to 2'b00.
  - Undefined:
    - No port.
    - redirect_pc loaded unmodified; low bits are carried into fetch addresses.

Decomposition:
- Types.v (shared package) holds:
  - `instruction (32-bit) and `instructionAddrPath (32-bit) width macros.
  - RESET_VECTOR.
  - NOP_INSTR constant.
  - PC increment constant 4.
- Sub-module if_fetch_fifo: DEPTH-entry show-ahead FIFO of {pc, instr}, with push, pop, flush, count, empty and full.
- The pc queue reuses if_fetch_fifo with the instruction field tied off, or is a second narrow instance.

Test Plan:
- Reset then idle memory (ready=1, 1-cycle rsp): pc_o sequence 0x0, 0x4, 0x8, 0xC on valid_o, one per cycle after fill; instructions match the memory image.
- stall=1 for 5 cycles with FIFO full: pc_o/instruction_o held; imem_req_valid=0 once count+inflight reaches 2; no word lost after release.
- Redirect to 0x100 with 2 requests inflight: both responses dropped; next valid_o has pc_o=0x100.
- Redirect coincident with a rsp and with stall=1: rsp dropped, head flushed; valid_o=0 next cycle; then 0x100, 0x104 stream.
- fpc=0xFFFF_FFFC, accept: next imem_req_addr=0x0000_0000.
- rst=0 asserted mid-stream with 2 entries buffered: next cycle valid_o=0, pc_o=RESET_VECTOR; refetch from RESET_VECTOR. With IF_MISALIGN_CHECK_EN, redirect to 0x102 gives misalign_o=1 and a fetch at 0x100.
